wb_merge_buffer: RTL and testbench

//  Parametrised writeback stage: merges NUM_CH result channels (ALU, load, mul/div, ...) onto the

---
 rtl/wb_pkg.sv | 15 +
 rtl/wb_chan_fifo.sv | 62 ++++++
 rtl/wb_merge_buffer.sv | 117 +++++++++++
 tb/tb_wb_merge_buffer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared constants for the writeback merge stage: default widths, the
// hard-wired zero register, and the reset/write-enable encodings.
package wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;

    localparam logic [WB_ADDR_W-1:0] ZERO_REG_ADDR = '0;
    localparam logic [WB_DATA_W-1:0] ZERO_WORD     = '0;

    localparam logic RST_ENABLE    = 1'b1;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

endpackage : wb_pkg

// File: rtl/wb_chan_fifo.sv
// Per-channel result FIFO. Power-of-two depth, free-running wrapping
// pointers, and an occupancy count that runs 0..DEPTH. A push into a full
// FIFO or a pop from an empty one is ignored.
module wb_chan_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = WB_ADDR_W + WB_DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; push and pop in one cycle leave count unchanged.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage write.
    // NOTE: the entry array is deliberately not reset; an entry is only ever
    // read after it has been written, so clearing it would buy nothing.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule : wb_chan_fifo

// File: rtl/wb_merge_buffer.sv
// Writeback merge stage: NUM_CH producer channels each feed a FIFO, and a
// round-robin arbiter drains one entry per cycle into the registered
// RegFile write port. Beats for register $0 or with we=0 are accepted and
// dropped at the FIFO input.
module wb_merge_buffer
    import wb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 4,
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          in_valid,
    output logic [NUM_CH-1:0]          in_ready,
    input  logic [NUM_CH-1:0]          in_we,
    input  logic [NUM_CH*ADDR_W-1:0]   in_addr,
    input  logic [NUM_CH*DATA_W-1:0]   in_result,
    output logic                       write_reg_en_out,
    output logic [ADDR_W-1:0]          write_reg_addr_out,
    output logic [DATA_W-1:0]          result_out,
    output logic                       idle
);

    localparam int CH_W    = $clog2(NUM_CH);
    localparam int ENTRY_W = ADDR_W + DATA_W;
    localparam logic [CH_W-1:0]   CH_ONE  = CH_W'(1);
    localparam logic [CH_W-1:0]   CH_LAST = CH_W'(NUM_CH - 1);
    localparam logic [NUM_CH-1:0] GNT_ONE = NUM_CH'(1);

    logic [NUM_CH-1:0]  fifo_empty;
    logic [NUM_CH-1:0]  fifo_full;
    logic [NUM_CH-1:0]  push;
    logic [NUM_CH-1:0]  grant;
    logic [ENTRY_W-1:0] fifo_dout [NUM_CH];
    logic [CH_W-1:0]    rr_ptr;
    logic [CH_W-1:0]    grant_idx;
    logic [CH_W-1:0]    next_rr;
    logic               any_grant;

    // Ready depends only on registered occupancy, never on in_valid.
    assign in_ready = ~fifo_full;
    assign idle     = (&fifo_empty) & ~write_reg_en_out;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        logic [ADDR_W-1:0] ch_addr;
        logic [DATA_W-1:0] ch_data;

        assign ch_addr = in_addr[c*ADDR_W +: ADDR_W];
        assign ch_data = in_result[c*DATA_W +: DATA_W];
        assign push[c] = in_valid[c] & in_ready[c] & in_we[c]
                       & (ch_addr != ADDR_W'(ZERO_REG_ADDR));

        wb_chan_fifo #(
            .DEPTH (DEPTH),
            .WIDTH (ENTRY_W)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[c]),
            .pop   (grant[c]),
            .din   ({ch_addr, ch_data}),
            .dout  (fifo_dout[c]),
            .empty (fifo_empty[c]),
            .full  (fifo_full[c])
        );
    end

    // Round-robin pick: lowest requester at or above rr_ptr, else lowest overall.
    always_comb begin
        logic [NUM_CH-1:0] req;
        logic [NUM_CH-1:0] high_mask;
        logic [NUM_CH-1:0] masked;

        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        req       = ~fifo_empty;
        high_mask = '0;
        grant_idx = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            high_mask[c] = (CH_W'(c) >= rr_ptr);
        end
        masked = req & high_mask;

        // Descending scans so the lowest set bit is the last one written.
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (req[c]) grant_idx = CH_W'(c);
        end
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (masked[c]) grant_idx = CH_W'(c);
        end

        any_grant = |req;
        grant     = any_grant ? (GNT_ONE << grant_idx) : '0;
        next_rr   = (grant_idx == CH_LAST) ? '0 : grant_idx + CH_ONE;
    end

    // Registered write port and arbiter pointer; address/data hold when idle.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            write_reg_en_out   <= WRITE_DISABLE;
            write_reg_addr_out <= ADDR_W'(ZERO_REG_ADDR);
            result_out         <= DATA_W'(ZERO_WORD);
            rr_ptr             <= '0;
        end else if (any_grant) begin
            write_reg_en_out                  <= WRITE_ENABLE;
            {write_reg_addr_out, result_out}  <= fifo_dout[grant_idx];
            rr_ptr                            <= next_rr;
        end else begin
            write_reg_en_out <= WRITE_DISABLE;
        end
    end

endmodule : wb_merge_buffer

// File: tb/tb_wb_merge_buffer.sv
// Directed bench for wb_merge_buffer with NUM_CH=4, DEPTH=4, DATA_W=32,
// ADDR_W=5. Inputs change 1 ns after a rising edge; outputs are checked at
// the same point, so each check sees the state left by the edge just passed.
module tb_wb_merge_buffer;

    localparam int NUM_CH = 4;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic                     clk;
    logic                     rst;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH-1:0]        in_ready;
    logic [NUM_CH-1:0]        in_we;
    logic [NUM_CH*ADDR_W-1:0] in_addr;
    logic [NUM_CH*DATA_W-1:0] in_result;
    logic                     write_reg_en_out;
    logic [ADDR_W-1:0]        write_reg_addr_out;
    logic [DATA_W-1:0]        result_out;
    logic                     idle;

    int vectors;
    int miscompares;

    wb_merge_buffer #(
        .NUM_CH (NUM_CH),
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_we              (in_we),
        .in_addr            (in_addr),
        .in_result          (in_result),
        .write_reg_en_out   (write_reg_en_out),
        .write_reg_addr_out (write_reg_addr_out),
        .result_out         (result_out),
        .idle               (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input logic we, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d);
        in_valid[c]                = 1'b1;
        in_we[c]                   = we;
        in_addr[c*ADDR_W +: ADDR_W] = a;
        in_result[c*DATA_W +: DATA_W] = d;
    endtask

    task automatic clear_in();
        in_valid = '0;
    endtask

    task automatic expect_wr(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        tick();
        check({tag, ".en"},   write_reg_en_out,   1'b1);
        check({tag, ".addr"}, write_reg_addr_out, a);
        check({tag, ".data"}, result_out,         d);
    endtask

    task automatic expect_no_wr(input string tag);
        tick();
        check({tag, ".en"}, write_reg_en_out, 1'b0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        in_valid    = '0;
        in_we       = '0;
        in_addr     = '0;
        in_result   = '0;

        // 1. Reset held two cycles with every channel offering a beat.
        rst = 1'b1;
        for (int c = 0; c < NUM_CH; c++) set_ch(c, 1'b1, ADDR_W'(c + 1), 32'h5000 + DATA_W'(c));
        tick();
        tick();
        check("rst.en",    write_reg_en_out,   1'b0);
        check("rst.addr",  write_reg_addr_out, 5'd0);
        check("rst.data",  result_out,         32'h0);
        check("rst.idle",  idle,               1'b1);
        check("rst.ready", in_ready,           4'hF);
        rst = 1'b0;
        clear_in();
        tick();
        check("post_rst.idle", idle, 1'b1);
        check("post_rst.en",   write_reg_en_out, 1'b0);
        tick();
        check("post_rst2.idle", idle, 1'b1);

        // 2. Single beat on ch1: visible only after the following edge.
        set_ch(1, 1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        clear_in();
        check("single.k.en",   write_reg_en_out, 1'b0);
        check("single.k.idle", idle,             1'b0);
        expect_wr("single", 5'd5, 32'hDEADBEEF);
        check("single.busy_idle", idle, 1'b0);
        expect_no_wr("single.after");
        check("single.hold_addr", write_reg_addr_out, 5'd5);
        check("single.idle",      idle,               1'b1);

        // 3. Register $0 and we=0 beats are accepted but dropped.
        set_ch(0, 1'b1, 5'd0, 32'h1111);
        set_ch(2, 1'b0, 5'd7, 32'h2222);
        check("zero.ready", in_ready, 4'hF);
        tick();
        clear_in();
        check("zero.idle", idle, 1'b1);
        check("zero.en",   write_reg_en_out, 1'b0);
        expect_no_wr("zero.next");

        // RR pointer sits at ch2 after the ch1 grant; a ch3 grant moves it to ch0.
        set_ch(3, 1'b1, 5'd9, 32'h99);
        tick();
        clear_in();
        expect_wr("align", 5'd9, 32'h99);
        expect_no_wr("align.after");

        // 4. Contention: all four channels at once, drained ch0..ch3.
        for (int c = 0; c < NUM_CH; c++) set_ch(c, 1'b1, ADDR_W'(c + 1), 32'hA0 + DATA_W'(c));
        tick();
        clear_in();
        expect_wr("burst_a.0", 5'd1, 32'hA0);
        expect_wr("burst_a.1", 5'd2, 32'hA1);
        expect_wr("burst_a.2", 5'd3, 32'hA2);
        expect_wr("burst_a.3", 5'd4, 32'hA3);
        expect_no_wr("burst_a.end");
        // Next burst starts from ch0; leaves pointer at ch3.
        set_ch(0, 1'b1, 5'd6, 32'hB0);
        set_ch(2, 1'b1, 5'd8, 32'hB2);
        tick();
        clear_in();
        expect_wr("burst_b.0", 5'd6, 32'hB0);
        expect_wr("burst_b.1", 5'd8, 32'hB2);
        expect_no_wr("burst_b.end");
        // Pointer at ch3: ch3 wins over the lower-numbered ch1.
        set_ch(1, 1'b1, 5'd10, 32'hC1);
        set_ch(3, 1'b1, 5'd12, 32'hC3);
        tick();
        clear_in();
        expect_wr("burst_c.0", 5'd12, 32'hC3);
        expect_wr("burst_c.1", 5'd10, 32'hC1);
        expect_no_wr("burst_c.end");
        // Pointer at ch2; a lone ch3 grant returns it to ch0.
        set_ch(3, 1'b1, 5'd13, 32'hD3);
        tick();
        clear_in();
        expect_wr("burst_d", 5'd13, 32'hD3);
        expect_no_wr("burst_d.end");

        // 5. Fill ch3 while ch0..ch2 hold the arbiter for three cycles.
        set_ch(0, 1'b1, 5'd1, 32'hE0);
        set_ch(1, 1'b1, 5'd2, 32'hE1);
        set_ch(2, 1'b1, 5'd3, 32'hE2);
        set_ch(3, 1'b1, 5'd20, 32'h10);
        check("full.ready0", in_ready[3], 1'b1);
        tick();
        in_valid[2:0] = '0;
        set_ch(3, 1'b1, 5'd20, 32'h11);
        check("full.ready1", in_ready[3], 1'b1);
        expect_wr("full.ch0", 5'd1, 32'hE0);
        set_ch(3, 1'b1, 5'd20, 32'h12);
        check("full.ready2", in_ready[3], 1'b1);
        expect_wr("full.ch1", 5'd2, 32'hE1);
        set_ch(3, 1'b1, 5'd20, 32'h13);
        check("full.ready3", in_ready[3], 1'b1);
        expect_wr("full.ch2", 5'd3, 32'hE2);
        // Four entries held: ready low through the pop cycle; this beat must be refused.
        set_ch(3, 1'b1, 5'd21, 32'h77);
        check("full.ready_low", in_ready[3], 1'b0);
        expect_wr("full.pop0", 5'd20, 32'h10);
        clear_in();
        check("full.ready_back", in_ready[3], 1'b1);
        expect_wr("full.pop1", 5'd20, 32'h11);
        expect_wr("full.pop2", 5'd20, 32'h12);
        expect_wr("full.pop3", 5'd20, 32'h13);
        expect_no_wr("full.end");
        check("full.idle", idle, 1'b1);

        // 6. Reset with entries buffered on ch0/ch1 and a grant pending.
        set_ch(0, 1'b1, 5'd14, 32'hF0);
        set_ch(1, 1'b1, 5'd15, 32'hF1);
        tick();
        set_ch(0, 1'b1, 5'd16, 32'hF2);
        in_valid[1] = 1'b0;
        check("midrst.idle_before", idle, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_in();
        check("midrst.en",    write_reg_en_out,   1'b0);
        check("midrst.addr",  write_reg_addr_out, 5'd0);
        check("midrst.data",  result_out,         32'h0);
        check("midrst.idle",  idle,               1'b1);
        check("midrst.ready", in_ready,           4'hF);
        expect_no_wr("midrst.n1");
        expect_no_wr("midrst.n2");
        check("midrst.idle2", idle, 1'b1);
        set_ch(1, 1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        clear_in();
        check("again.k.en", write_reg_en_out, 1'b0);
        expect_wr("again", 5'd5, 32'hDEADBEEF);
        expect_no_wr("again.after");
        check("again.idle", idle, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_wb_merge_buffer
